// File: rtl/cpu_debug.sv
// Debug access unit: halts, steps and resumes the core and gives the debug
// transport access to PC and GPRs. Optional breakpoint: CPU_DEBUG_BREAKPOINT_EN.
module cpu_debug #(
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rd_wr,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    input  logic        step,
    input  logic        run,
    output logic        halt,
    input  logic [31:0] pc_in,
    output logic        pc_we,
    output logic [31:0] pc_wdata,
    output logic [4:0]  gpr_addr,
    input  logic [31:0] gpr_rdata,
    output logic        gpr_we,
    output logic [31:0] gpr_wdata
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        enable_q, step_q, run_q;
    logic        acc_edge, step_edge, run_edge;
    logic        rd_acc, wr_acc;
    logic [6:0]  word_idx;
    logic [4:0]  gpr_idx;
    logic        sel_ctrl, sel_pc, sel_bp, sel_gpr;
    logic        is_halted;
    logic        ctrl_wr, dropped_wr;
    logic        err_q, err_d;
    logic [31:0] data_in_q, data_in_d;
    logic        pc_we_q, pc_we_d;
    logic [31:0] pc_wdata_q, pc_wdata_d;
    logic        gpr_we_q, gpr_we_d;
    logic [4:0]  gpr_addr_q, gpr_addr_d;
    logic [31:0] gpr_wdata_q, gpr_wdata_d;
    logic        bp_match, bp_hit;
    logic [31:0] bpaddr;
    logic        unused_addr_bits;

    assign acc_edge  = enable & ~enable_q;
    assign step_edge = step & ~step_q;
    assign run_edge  = run & ~run_q;
    assign rd_acc    = acc_edge & ~rd_wr;
    assign wr_acc    = acc_edge & rd_wr;

    // Only address[8:2] is decoded; the rest of the address aliases.
    assign word_idx  = address[8:2];
    assign gpr_idx   = address[6:2];
    assign sel_ctrl  = (word_idx == 7'h00);
    assign sel_pc    = (word_idx == 7'h01);
    assign sel_bp    = (word_idx == 7'h02);
    assign sel_gpr   = (word_idx[6:5] == 2'b10);
    assign unused_addr_bits = ^{address[31:9], address[1:0]};

    assign is_halted  = (state_q == ST_HALTED);
    assign ctrl_wr    = wr_acc & sel_ctrl;
    assign dropped_wr = wr_acc & (sel_pc | sel_gpr) & ~is_halted;

`ifdef CPU_DEBUG_BREAKPOINT_EN
    logic [31:0] bpaddr_q;
    logic        bp_hit_q;
    logic        left_halt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bpaddr_q    <= 32'h0;
            bp_hit_q    <= 1'b0;
            left_halt_q <= 1'b0;
        end else begin
            left_halt_q <= (state_q != ST_RUN);
            if (wr_acc && sel_bp) begin
                bpaddr_q <= {data_out[31:2], 1'b0, data_out[0]};
            end
            if (bp_match) begin
                bp_hit_q <= 1'b1;
            end else if (ctrl_wr && data_out[2]) begin
                bp_hit_q <= 1'b0;
            end
        end
    end

    // Skipping the first RUN cycle lets the core resume from the breakpoint PC.
    assign bp_match = (state_q == ST_RUN) && !left_halt_q && bpaddr_q[0] &&
                      (pc_in[31:2] == bpaddr_q[31:2]);
    assign bp_hit   = bp_hit_q;
    assign bpaddr   = bpaddr_q;
`else
    assign bp_match = 1'b0;
    assign bp_hit   = 1'b0;
    assign bpaddr   = 32'h0;
`endif

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        data_in_d   = data_in_q;
        pc_we_d     = 1'b0;
        pc_wdata_d  = pc_wdata_q;
        gpr_we_d    = 1'b0;
        gpr_addr_d  = gpr_addr_q;
        gpr_wdata_d = gpr_wdata_q;

        // Later assignments take priority; a run edge overrides everything.
        if (state_q == ST_STEP) begin
            state_d = ST_HALTED;
        end
        if (bp_match) begin
            state_d = ST_HALTED;
        end
        if (step_edge && is_halted) begin
            state_d = ST_STEP;
        end
        if (ctrl_wr && data_out[1]) begin
            state_d = ST_RUN;
        end
        if (ctrl_wr && data_out[0]) begin
            state_d = ST_HALTED;
        end
        if (run_edge) begin
            state_d = ST_RUN;
        end

        if (ctrl_wr && data_out[3]) begin
            err_d = 1'b0;
        end
        if (dropped_wr) begin
            err_d = 1'b1;
        end

        if (rd_acc) begin
            if (sel_ctrl) begin
                data_in_d = {28'h0, err_q, bp_hit, state_q == ST_STEP, is_halted};
            end else if (sel_pc) begin
                data_in_d = pc_in;
            end else if (sel_bp) begin
                data_in_d = bpaddr;
            end else if (sel_gpr) begin
                data_in_d = gpr_rdata;
            end else begin
                data_in_d = 32'h0;
            end
        end

        if (wr_acc && sel_pc && is_halted) begin
            pc_we_d    = 1'b1;
            pc_wdata_d = data_out;
        end
        if (wr_acc && sel_gpr && is_halted && (gpr_idx != 5'd0)) begin
            gpr_we_d    = 1'b1;
            gpr_addr_d  = gpr_idx;
            gpr_wdata_d = data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_HALTED) begin
                state_q <= ST_HALTED;
            end else begin
                state_q <= ST_RUN;
            end
            enable_q    <= 1'b0;
            step_q      <= 1'b0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
            data_in_q   <= 32'h0;
            pc_we_q     <= 1'b0;
            pc_wdata_q  <= 32'h0;
            gpr_we_q    <= 1'b0;
            gpr_addr_q  <= 5'd0;
            gpr_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable;
            step_q      <= step;
            run_q       <= run;
            err_q       <= err_d;
            data_in_q   <= data_in_d;
            pc_we_q     <= pc_we_d;
            pc_wdata_q  <= pc_wdata_d;
            gpr_we_q    <= gpr_we_d;
            gpr_addr_q  <= gpr_addr_d;
            gpr_wdata_q <= gpr_wdata_d;
        end
    end

    // A GPR read steers the combinational register-file port during the detect cycle.
    assign gpr_addr  = (rd_acc && sel_gpr) ? gpr_idx : gpr_addr_q;
    assign halt      = is_halted;
    assign data_in   = data_in_q;
    assign pc_we     = pc_we_q;
    assign pc_wdata  = pc_wdata_q;
    assign gpr_we    = gpr_we_q;
    assign gpr_wdata = gpr_wdata_q;

endmodule

// File: tb/tb_cpu_debug.sv
// Self-checking bench for cpu_debug: directed scenarios plus a randomized
// access/step/run sequence checked against a transaction-level model.
module tb_cpu_debug;

    localparam logic [31:0] RF_SEED = 32'h5A17C3E9;
    localparam int M_RUN  = 0;
    localparam int M_HALT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, rd_wr = 1'b0, step = 1'b0, run = 1'b0;
    logic [31:0] address = 32'h0, data_out = 32'h0, pc_in = 32'h0;
    logic [31:0] data_in, pc_wdata, gpr_rdata, gpr_wdata;
    logic        halt, pc_we, gpr_we;
    logic [4:0]  gpr_addr;
    logic [31:0] h_data_in, h_pc_wdata, h_gpr_rdata, h_gpr_wdata;
    logic        h_halt, h_pc_we, h_gpr_we;
    logic [4:0]  h_gpr_addr;

    int nchk = 0;
    int nerr = 0;

    // Observations captured by acc()
    logic        o_halt_det, o_halt1, o_pc_we1, o_pc_we2, o_gpr_we1, o_gpr_we2;
    logic [4:0]  o_gaddr_det, o_gaddr1;
    logic [31:0] o_pc_wdata1, o_gpr_wdata1, o_data_in;
    logic        s1, s2, s3;

    // Reference model state
    int          m_mode;
    logic        m_err, m_bphit;
    logic [31:0] m_bpaddr, m_data_in;

    always #5 clk = ~clk;

    // Stand-in register file: a fixed pattern per index
    function automatic logic [31:0] rf_val(input logic [4:0] i);
        return RF_SEED ^ ({27'h0, i} * 32'h9E3779B1);
    endfunction

    assign gpr_rdata   = rf_val(gpr_addr);
    assign h_gpr_rdata = rf_val(h_gpr_addr);

    cpu_debug #(.RESET_HALTED(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rd_wr(rd_wr),
        .address(address), .data_out(data_out), .data_in(data_in),
        .step(step), .run(run), .halt(halt), .pc_in(pc_in),
        .pc_we(pc_we), .pc_wdata(pc_wdata), .gpr_addr(gpr_addr),
        .gpr_rdata(gpr_rdata), .gpr_we(gpr_we), .gpr_wdata(gpr_wdata)
    );

    cpu_debug #(.RESET_HALTED(1'b1)) dut_h (
        .clk(clk), .reset(reset), .enable(enable), .rd_wr(rd_wr),
        .address(address), .data_out(data_out), .data_in(h_data_in),
        .step(step), .run(run), .halt(h_halt), .pc_in(pc_in),
        .pc_we(h_pc_we), .pc_wdata(h_pc_wdata), .gpr_addr(h_gpr_addr),
        .gpr_rdata(h_gpr_rdata), .gpr_we(h_gpr_we), .gpr_wdata(h_gpr_wdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; enable = 1'b0; step = 1'b0; run = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One debug access: enable high for one cycle, then low for one cycle
    task automatic acc(input logic wr, input logic [31:0] a, input logic [31:0] d);
        rd_wr = wr; address = a; data_out = d; enable = 1'b1;
        #1;
        o_halt_det  = halt;
        o_gaddr_det = gpr_addr;
        tick();
        o_halt1      = halt;
        o_data_in    = data_in;
        o_pc_we1     = pc_we;
        o_pc_wdata1  = pc_wdata;
        o_gpr_we1    = gpr_we;
        o_gaddr1     = gpr_addr;
        o_gpr_wdata1 = gpr_wdata;
        enable = 1'b0;
        tick();
        o_pc_we2  = pc_we;
        o_gpr_we2 = gpr_we;
        $display("acc wr=%0d addr=%h wdata=%h data_in=%h halt=%b pc_we=%b gpr_we=%b",
                 wr, a, d, o_data_in, o_halt1, o_pc_we1, o_gpr_we1);
    endtask

    task automatic pulse_step;
        step = 1'b1;
        tick(); s1 = halt;
        step = 1'b0;
        tick(); s2 = halt;
        tick(); s3 = halt;
        $display("step halt=%b%b%b", s1, s2, s3);
    endtask

    task automatic pulse_run;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); s1 = halt;
        $display("run halt=%b", s1);
    endtask

    task automatic test_reset;
        do_reset();
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL reset_halt0: got %b want 0", halt); end
        nchk++; if (h_halt !== 1'b1) begin nerr++; $display("FAIL reset_halt1: got %b want 1", h_halt); end
        nchk++; if (data_in !== 32'h0) begin nerr++; $display("FAIL reset_data_in: got %h want 0", data_in); end
        nchk++; if (pc_we !== 1'b0 || h_pc_we !== 1'b0) begin nerr++; $display("FAIL reset_pc_we: got %b%b want 00", pc_we, h_pc_we); end
        nchk++; if (gpr_we !== 1'b0 || h_gpr_we !== 1'b0) begin nerr++; $display("FAIL reset_gpr_we: got %b%b want 00", gpr_we, h_gpr_we); end
        nchk++; if (gpr_addr !== 5'd0) begin nerr++; $display("FAIL reset_gpr_addr: got %0d want 0", gpr_addr); end
        nchk++; if (pc_wdata !== 32'h0 || h_pc_wdata !== 32'h0) begin nerr++; $display("FAIL reset_pc_wdata: got %h want 0", pc_wdata); end
        nchk++; if (gpr_wdata !== 32'h0 || h_gpr_wdata !== 32'h0) begin nerr++; $display("FAIL reset_gpr_wdata: got %h want 0", gpr_wdata); end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h0) begin nerr++; $display("FAIL reset_ctrl_run: got %h want 0", o_data_in); end
        nchk++; if (h_data_in !== 32'h1) begin nerr++; $display("FAIL reset_ctrl_halted: got %h want 1", h_data_in); end
    endtask

    task automatic test_ctrl_halt;
        do_reset();
        acc(1'b1, 32'h0, 32'h1);
        nchk++; if (o_halt_det !== 1'b0) begin nerr++; $display("FAIL halt_early: got %b want 0", o_halt_det); end
        nchk++; if (o_halt1 !== 1'b1) begin nerr++; $display("FAIL halt_after_write: got %b want 1", o_halt1); end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h1) begin nerr++; $display("FAIL ctrl_read_halted: got %h want 1", o_data_in); end
    endtask

    task automatic test_step;
        pulse_step();
        nchk++; if ({s1, s2, s3} !== 3'b011) begin nerr++; $display("FAIL step_halted: got %b%b%b want 011", s1, s2, s3); end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h1) begin nerr++; $display("FAIL step_ctrl: got %h want 1", o_data_in); end
        pulse_run();
        nchk++; if (s1 !== 1'b0) begin nerr++; $display("FAIL run_pulse: got %b want 0", s1); end
        pulse_step();
        nchk++; if ({s1, s2, s3} !== 3'b000) begin nerr++; $display("FAIL step_running: got %b%b%b want 000", s1, s2, s3); end
    endtask

    task automatic test_gpr_pc;
        acc(1'b1, 32'h0, 32'h1);
        acc(1'b1, 32'h114, 32'h12345678);
        nchk++; if (o_gpr_we1 !== 1'b1 || o_gpr_we2 !== 1'b0) begin nerr++; $display("FAIL gpr_we_pulse: got %b%b want 10", o_gpr_we1, o_gpr_we2); end
        nchk++; if (o_gaddr1 !== 5'd5) begin nerr++; $display("FAIL gpr_addr_wr: got %0d want 5", o_gaddr1); end
        nchk++; if (o_gpr_wdata1 !== 32'h12345678) begin nerr++; $display("FAIL gpr_wdata: got %h want 12345678", o_gpr_wdata1); end
        acc(1'b1, 32'h100, 32'hDEADBEEF);
        nchk++; if (o_gpr_we1 !== 1'b0 || o_gpr_we2 !== 1'b0) begin nerr++; $display("FAIL gpr_x0_write: got %b%b want 00", o_gpr_we1, o_gpr_we2); end
        acc(1'b0, 32'h114, 32'h0);
        nchk++; if (o_gaddr_det !== 5'd5) begin nerr++; $display("FAIL gpr_addr_rd: got %0d want 5", o_gaddr_det); end
        nchk++; if (o_data_in !== rf_val(5'd5)) begin nerr++; $display("FAIL gpr_read: got %h want %h", o_data_in, rf_val(5'd5)); end
        acc(1'b1, 32'h4, 32'hCAFE0010);
        nchk++; if (o_pc_we1 !== 1'b1 || o_pc_we2 !== 1'b0) begin nerr++; $display("FAIL pc_we_pulse: got %b%b want 10", o_pc_we1, o_pc_we2); end
        nchk++; if (o_pc_wdata1 !== 32'hCAFE0010) begin nerr++; $display("FAIL pc_wdata: got %h want cafe0010", o_pc_wdata1); end
        pc_in = 32'h00001230;
        acc(1'b0, 32'h4, 32'h0);
        nchk++; if (o_data_in !== 32'h00001230) begin nerr++; $display("FAIL pc_read: got %h want 00001230", o_data_in); end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h1) begin nerr++; $display("FAIL ctrl_no_err: got %h want 1", o_data_in); end
    endtask

    task automatic test_write_err;
        pulse_run();
        acc(1'b1, 32'h4, 32'h55);
        nchk++; if (o_pc_we1 !== 1'b0 || o_pc_we2 !== 1'b0) begin nerr++; $display("FAIL pc_write_running: got %b%b want 00", o_pc_we1, o_pc_we2); end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h8) begin nerr++; $display("FAIL err_set: got %h want 8", o_data_in); end
        acc(1'b1, 32'h120, 32'h1);
        nchk++; if (o_gpr_we1 !== 1'b0 || o_gpr_we2 !== 1'b0) begin nerr++; $display("FAIL gpr_write_running: got %b%b want 00", o_gpr_we1, o_gpr_we2); end
        acc(1'b1, 32'h0, 32'h8);
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h0) begin nerr++; $display("FAIL err_clear: got %h want 0", o_data_in); end
        acc(1'b0, 32'h4, 32'h0);
        acc(1'b0, 32'h0C, 32'h0);
        nchk++; if (o_data_in !== 32'h0) begin nerr++; $display("FAIL unmapped_0c: got %h want 0", o_data_in); end
        acc(1'b0, 32'h4, 32'h0);
        acc(1'b0, 32'h180, 32'h0);
        nchk++; if (o_data_in !== 32'h0) begin nerr++; $display("FAIL unmapped_180: got %h want 0", o_data_in); end
    endtask

    task automatic test_breakpoint;
        do_reset();
        pc_in = 32'h38;
        acc(1'b1, 32'h8, 32'h41);
        acc(1'b0, 32'h8, 32'h0);
`ifdef CPU_DEBUG_BREAKPOINT_EN
        nchk++; if (o_data_in !== 32'h41) begin nerr++; $display("FAIL bpaddr_read: got %h want 41", o_data_in); end
        tick();
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL bp_38: got %b want 0", halt); end
        pc_in = 32'h3C; tick();
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL bp_3c: got %b want 0", halt); end
        pc_in = 32'h40; tick();
        nchk++; if (halt !== 1'b1) begin nerr++; $display("FAIL bp_40: got %b want 1", halt); end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h5) begin nerr++; $display("FAIL bp_ctrl: got %h want 5", o_data_in); end
        run = 1'b1; tick(); run = 1'b0;
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL bp_resume: got %b want 0", halt); end
        tick();
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL bp_suppress: got %b want 0", halt); end
        pc_in = 32'h44; tick(); tick();
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL bp_moved_on: got %b want 0", halt); end
        acc(1'b1, 32'h0, 32'h4);
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h0) begin nerr++; $display("FAIL bp_hit_clear: got %h want 0", o_data_in); end
`else
        nchk++; if (o_data_in !== 32'h0) begin nerr++; $display("FAIL bpaddr_absent: got %h want 0", o_data_in); end
        pc_in = 32'h3C; tick();
        pc_in = 32'h40; tick(); tick();
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL bp_absent_halt: got %b want 0", halt); end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== 32'h0) begin nerr++; $display("FAIL bp_absent_ctrl: got %h want 0", o_data_in); end
`endif
    endtask

    task automatic test_run_step_same;
        acc(1'b1, 32'h0, 32'h1);
        run = 1'b1; step = 1'b1;
        tick(); s1 = halt;
        run = 1'b0; step = 1'b0;
        tick(); s2 = halt;
        tick(); s3 = halt;
        nchk++; if ({s1, s2, s3} !== 3'b000) begin nerr++; $display("FAIL run_beats_step: got %b%b%b want 000", s1, s2, s3); end
    endtask

    task automatic test_reset_aborts;
        acc(1'b1, 32'h0, 32'h1);
        step = 1'b1; tick(); step = 1'b0;
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL in_step: got %b want 0", halt); end
        reset = 1'b1; tick(); reset = 1'b0;
        nchk++; if (halt !== 1'b0 || h_halt !== 1'b1) begin nerr++; $display("FAIL reset_in_step: got %b%b want 01", halt, h_halt); end
        tick();
        nchk++; if (halt !== 1'b0) begin nerr++; $display("FAIL reset_step_after: got %b want 0", halt); end
        acc(1'b1, 32'h0, 32'h1);
        rd_wr = 1'b1; address = 32'h4; data_out = 32'h77; enable = 1'b1; reset = 1'b1;
        tick(); s1 = pc_we;
        enable = 1'b0; tick(); s2 = pc_we;
        reset = 1'b0; tick(); s3 = pc_we;
        nchk++; if ({s1, s2, s3} !== 3'b000) begin nerr++; $display("FAIL reset_mid_access: got %b%b%b want 000", s1, s2, s3); end
    endtask

    task automatic test_random;
        logic [31:0] a, d;
        logic [8:0]  a9;
        logic        wr, e_pcwe, e_gprwe;
        int          k;
        do_reset();
        m_mode = M_RUN; m_err = 1'b0; m_bphit = 1'b0; m_bpaddr = 32'h0; m_data_in = 32'h0;
        for (int it = 0; it < 160; it++) begin
            k = $urandom_range(0, 11);
            if (k == 0) begin
                pulse_run();
                m_mode = M_RUN;
                nchk++; if (s1 !== 1'b0) begin nerr++; $display("FAIL rnd_run: got %b want 0", s1); end
            end else if (k == 1) begin
                pulse_step();
                nchk++;
                if ({s1, s2, s3} !== ((m_mode == M_HALT) ? 3'b011 : 3'b000)) begin
                    nerr++; $display("FAIL rnd_step: got %b%b%b mode %0d", s1, s2, s3, m_mode);
                end
            end else begin
                k = $urandom_range(0, 39);
                if (k < 32)       a = 32'h100 + 32'(k) * 4;
                else if (k < 34)  a = 32'h0;
                else if (k == 34) a = 32'h4;
                else if (k == 35) a = 32'h8;
                else if (k == 36) a = 32'h0C;
                else if (k == 37) a = 32'h0FC;
                else if (k == 38) a = 32'h180;
                else              a = 32'h1FC;
                a9 = a[8:0];
                wr = 1'($urandom_range(0, 1));
                d  = $urandom;
                if (a9 == 9'h008) d[0] = 1'b0;
                pc_in = {$urandom, 2'b00} & 32'hFFFF_FFFC;
                e_pcwe = 1'b0; e_gprwe = 1'b0;
                if (!wr) begin
                    if (a9 == 9'h000)      m_data_in = {28'h0, m_err, m_bphit, 1'b0, m_mode == M_HALT};
                    else if (a9 == 9'h004) m_data_in = pc_in;
                    else if (a9 == 9'h008) m_data_in = m_bpaddr;
                    else if (a9 >= 9'h100 && a9 <= 9'h17C) m_data_in = rf_val(a[6:2]);
                    else                   m_data_in = 32'h0;
                end else if (a9 == 9'h000) begin
                    if (d[3]) m_err = 1'b0;
                    if (d[2]) m_bphit = 1'b0;
                    if (d[0]) m_mode = M_HALT;
                    else if (d[1]) m_mode = M_RUN;
                end else if (a9 == 9'h004 || (a9 >= 9'h100 && a9 <= 9'h17C)) begin
                    if (m_mode != M_HALT) m_err = 1'b1;
                    else if (a9 == 9'h004) e_pcwe = 1'b1;
                    else if (a[6:2] != 5'd0) e_gprwe = 1'b1;
                end else if (a9 == 9'h008) begin
`ifdef CPU_DEBUG_BREAKPOINT_EN
                    m_bpaddr = {d[31:2], 2'b00};
`endif
                end
                acc(wr, a, d);
                nchk++; if (o_data_in !== m_data_in) begin nerr++; $display("FAIL rnd_data_in: addr %h got %h want %h", a, o_data_in, m_data_in); end
                nchk++; if (o_halt1 !== (m_mode == M_HALT)) begin nerr++; $display("FAIL rnd_halt: addr %h got %b want %b", a, o_halt1, m_mode == M_HALT); end
                nchk++; if ({o_pc_we1, o_pc_we2} !== {e_pcwe, 1'b0}) begin nerr++; $display("FAIL rnd_pc_we: got %b%b want %b0", o_pc_we1, o_pc_we2, e_pcwe); end
                nchk++; if ({o_gpr_we1, o_gpr_we2} !== {e_gprwe, 1'b0}) begin nerr++; $display("FAIL rnd_gpr_we: got %b%b want %b0", o_gpr_we1, o_gpr_we2, e_gprwe); end
                if (e_pcwe) begin
                    nchk++; if (o_pc_wdata1 !== d) begin nerr++; $display("FAIL rnd_pc_wdata: got %h want %h", o_pc_wdata1, d); end
                end
                if (e_gprwe) begin
                    nchk++; if (o_gaddr1 !== a[6:2] || o_gpr_wdata1 !== d) begin nerr++; $display("FAIL rnd_gpr_wr: got %0d/%h want %0d/%h", o_gaddr1, o_gpr_wdata1, a[6:2], d); end
                end
                if (!wr && a9 >= 9'h100 && a9 <= 9'h17C) begin
                    nchk++; if (o_gaddr_det !== a[6:2]) begin nerr++; $display("FAIL rnd_gpr_addr_rd: got %0d want %0d", o_gaddr_det, a[6:2]); end
                end
            end
        end
        acc(1'b0, 32'h0, 32'h0);
        nchk++; if (o_data_in !== {28'h0, m_err, m_bphit, 1'b0, m_mode == M_HALT}) begin nerr++; $display("FAIL rnd_final_ctrl: got %h", o_data_in); end
    endtask

    initial begin
        test_reset();
        test_ctrl_halt();
        test_step();
        test_gpr_pc();
        test_write_err();
        test_breakpoint();
        test_run_step_same();
        test_reset_aborts();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
